// File: rtl/nes_video_pkg.sv
// Shared video-stage types: palette geometry and RGB888 -> RGB555 packing.
package nes_video_pkg;

    localparam int PAL_ENTRIES    = 64;
    localparam int PAL_FILE_BYTES = 192;

    typedef struct packed {
        logic [4:0] b;
        logic [4:0] g;
        logic [4:0] r;
    } rgb555_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RX,
        ST_END,
        ST_FILL
    } pal_state_e;

    function automatic rgb555_t rgb888_to_555(input logic [7:0] r,
                                              input logic [7:0] g,
                                              input logic [7:0] b);
        rgb555_t c;
        c.b = b[7:3];
        c.g = g[7:3];
        c.r = r[7:3];
        return c;
    endfunction

endpackage

// File: rtl/pal_file_loader.sv
// Streams a 192-byte RGB888 palette file from ioctl into the 64-entry palette RAM.
// Latency: palette write strobe 1 cycle after the byte carrying B; no backpressure (ioctl is never stalled).
// Optional PAL_FILE_LOADER_FILL_EN: short downloads back-fill the remaining entries with black.
module pal_file_loader
    import nes_video_pkg::*;
#(
    parameter logic [7:0] PAL_IOCTL_INDEX = 8'd2,
    parameter int         ADDR_W          = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              load_color,
    output logic [5:0]        load_color_index,
    output logic [14:0]       load_color_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    pal_state_e  state_q;
    logic        sel_q;
    logic [7:0]  byte_cnt_q;
    logic [1:0]  phase_q;
    logic [5:0]  entry_q;
    logic        full_q;
    logic [7:0]  r_q;
    logic [7:0]  g_q;
    logic        load_color_q;
    logic [5:0]  load_idx_q;
    rgb555_t     load_dat_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;

    logic              sel;
    logic              sel_rise;
    logic [ADDR_W-1:0] exp_addr;
    logic              in_file;
    logic              file_complete;

    assign sel           = ioctl_download && (ioctl_index == PAL_IOCTL_INDEX);
    assign sel_rise      = sel && !sel_q;
    assign exp_addr      = {{(ADDR_W-8){1'b0}}, byte_cnt_q};
    assign in_file       = ioctl_addr < ADDR_W'(PAL_FILE_BYTES);
    assign file_complete = (byte_cnt_q == 8'(PAL_FILE_BYTES));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            // Treat sel as already high so a download in flight across reset is ignored.
            sel_q        <= 1'b1;
            byte_cnt_q   <= '0;
            phase_q      <= '0;
            entry_q      <= '0;
            full_q       <= 1'b0;
            r_q          <= '0;
            g_q          <= '0;
            load_color_q <= 1'b0;
            load_idx_q   <= '0;
            load_dat_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            sel_q        <= sel;
            load_color_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_rise) begin
                        state_q    <= ST_RX;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        byte_cnt_q <= '0;
                        phase_q    <= '0;
                        entry_q    <= '0;
                        full_q     <= 1'b0;
                    end
                end
                ST_RX: begin
                    if (!sel) begin
                        state_q <= ST_END;
                    end else if (ioctl_wr && in_file) begin
                        if (ioctl_addr != exp_addr) begin
                            error_q <= 1'b1;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 8'd1;
                            if (phase_q == 2'd0) begin
                                r_q     <= ioctl_dout;
                                phase_q <= 2'd1;
                            end else if (phase_q == 2'd1) begin
                                g_q     <= ioctl_dout;
                                phase_q <= 2'd2;
                            end else begin
                                load_color_q <= 1'b1;
                                load_idx_q   <= entry_q;
                                load_dat_q   <= rgb888_to_555(r_q, g_q, ioctl_dout);
                                phase_q      <= 2'd0;
                                if (entry_q == 6'(PAL_ENTRIES - 1)) begin
                                    full_q <= 1'b1;
                                end else begin
                                    entry_q <= entry_q + 6'd1;
                                end
                            end
                        end
                    end
                end
                ST_END: begin
                    done_q <= file_complete;
`ifdef PAL_FILE_LOADER_FILL_EN
                    if (file_complete) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_FILL;
                    end
`else
                    if (!file_complete) begin
                        error_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
`endif
                end
`ifdef PAL_FILE_LOADER_FILL_EN
                ST_FILL: begin
                    if (sel_rise) begin
                        state_q    <= ST_RX;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        byte_cnt_q <= '0;
                        phase_q    <= '0;
                        entry_q    <= '0;
                        full_q     <= 1'b0;
                    end else begin
                        // entry_q already points at the first entry the file never reached.
                        load_color_q <= 1'b1;
                        load_idx_q   <= entry_q;
                        load_dat_q   <= '0;
                        if (entry_q == 6'(PAL_ENTRIES - 1)) begin
                            full_q  <= 1'b1;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            entry_q <= entry_q + 6'd1;
                        end
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign load_color       = load_color_q;
    assign load_color_index = load_idx_q;
    assign load_color_data  = load_dat_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;

endmodule
